// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle DIV/DIVU engine: FSM states, EX op codes
// and ready levels.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic [7:0] ExeDivOp  = 8'b0001_1010;
    localparam logic [7:0] ExeDivuOp = 8'b0001_1011;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// result {remainder, quotient} destined for HI/LO.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    div_state_e         state_q, state_d;
    logic [CntW-1:0]    counter_q, counter_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend magnitude, shifts into quotient
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               ready_q, ready_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Wrap-around negation keeps |0x80000000| = 0x80000000 as an unsigned magnitude.
    always_comb begin
        shifted = {rem_q, dvd_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        quo_fix = neg_quo_q ? -dvd_q : dvd_q;
        rem_fix = neg_rem_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        ready_d   = DivResultNotReady;
        result_d  = result_q;

        case (state_q)
            DivFree: begin
                // A high ready_q means start still belongs to the op just finished.
                if (start && !annul && !ready_q) begin
                    state_d   = (opdata2 == '0) ? DivByZero : DivOn;
                    counter_d = '0;
                    rem_d     = '0;
                    dvd_d     = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
                    dvs_d     = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
                    neg_quo_d = signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                    neg_rem_d = signed_div && opdata1[WIDTH-1];
                end
            end
            DivByZero: begin
                if (annul) begin
                    state_d = DivFree;
                end else begin
                    dvd_d     = '0;
                    rem_d     = '0;
                    neg_quo_d = 1'b0;
                    neg_rem_d = 1'b0;
                    state_d   = DivEnd;
                end
            end
            DivOn: begin
                if (annul) begin
                    state_d = DivFree;
                end else begin
                    if (!diff[WIDTH]) begin
                        rem_d = diff[WIDTH-1:0];
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                    end
                    dvd_d     = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
                    counter_d = counter_q + CntW'(1);
                    if (counter_q == CntW'(WIDTH - 1)) begin
                        state_d = DivEnd;
                    end
                end
            end
            DivEnd: begin
                state_d = DivFree;
                if (!annul) begin
                    ready_d  = DivResultReady;
                    result_d = {rem_fix, quo_fix};
                end
            end
            default: state_d = DivFree;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= DivFree;
            counter_q <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ready_q   <= DivResultNotReady;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;
    assign stall  = start & ~ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotient/remainder pairs, ready latency,
// annul, divide-by-zero and asynchronous reset.
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    int errors = 0;
    int checks = 0;

    div_unit #(
        .WIDTH(32)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .signed_div(signed_div),
        .opdata1   (opdata1),
        .opdata2   (opdata2),
        .annul     (annul),
        .result    (result),
        .ready     (ready),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called just after a negedge; start is sampled at the next posedge (edge 0).
    task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int seen;
        logic stall_seen;
        seen       = -1;
        stall_seen = 1'b1;
        start      = 1'b1;
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        for (int k = 0; k <= lat + 5 && seen < 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready) seen = k;
            else if (stall !== 1'b1) stall_seen = 1'b0;
        end
        check_int({tag, " latency"}, seen, lat);
        check64({tag, " result"}, result, exp);
        check64({tag, " stall while busy"}, {63'd0, stall_seen}, 64'd1);
        check64({tag, " stall at ready"}, {63'd0, stall}, 64'd0);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check64({tag, " ready single pulse"}, {63'd0, ready}, 64'd0);
    endtask

    initial begin
        int seen;
        resetn     = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        annul      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check64("reset result", result, 64'd0);
        check64("reset ready", {63'd0, ready}, 64'd0);
        check64("reset stall", {63'd0, stall}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
        run_div("divu ffffffff/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);
        run_div("div 5/0", 1'b1, 32'd5, 32'd0, 64'd0, 2);
        run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                {32'd0, 32'h8000_0000}, 33);

        // Annul in ON after cycle 9; result must stay at the previous value.
        start      = 1'b1;
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0;
        seen  = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready) seen++;
        end
        check_int("annul no ready", seen, 0);
        check64("annul result kept", result, {32'd0, 32'h8000_0000});

        // Annul and start together in FREE: the op must not start.
        start   = 1'b1;
        annul   = 1'b1;
        opdata1 = 32'd77;
        opdata2 = 32'd5;
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0;
        run_div("divu 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        // Asynchronous reset mid-operation.
        start      = 1'b1;
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd7;
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1 resetn = 1'b0;
        #1;
        check64("async reset result", result, 64'd0);
        check64("async reset ready", {63'd0, ready}, 64'd0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        seen   = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready) seen++;
        end
        check_int("reset discards op", seen, 0);
        run_div("divu 50/5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
